// File: rtl/evt_merge_arbiter.sv
// Edge-detecting event merger: latches per-source edges with a timestamp and serialises them round-robin.
// Optional saturating drop counter enabled by defining EVT_MERGE_DROP_CNT_EN.
module evt_merge_arbiter #(
  parameter int               N_SRC = 4,
  parameter int               TS_W  = 16,
  parameter logic [N_SRC-1:0] POL   = {N_SRC{1'b0}},
  parameter int               ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] evt_in,
  input  logic [N_SRC-1:0] evt_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_id,
  output logic [TS_W-1:0]  out_ts,
  output logic             out_multi,
  output logic [N_SRC-1:0] ovf,
  input  logic             clr_ovf,
  output logic [15:0]      drop_cnt
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t           state;
  logic [TS_W-1:0]  ts_cnt;
  logic [TS_W-1:0]  ts_reg [N_SRC];
  logic [N_SRC-1:0] s1, s2, pend;
  logic [N_SRC-1:0] edge_det, set_req, load_hit, ovf_set;
  logic             arm1, armed;
  logic [ID_W-1:0]  ptr, sel;
  logic             found, load, multi;
  logic [4:0]       pcnt;

  assign out_valid = (state == PRESENT);

  always_comb begin
    edge_det = (s1 & ~s2 & ~POL) | (s2 & ~s1 & POL);
    set_req  = edge_det & evt_mask & {N_SRC{armed}};
  end

  // Cyclic search for the first pending source at or after ptr.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    pcnt  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_SRC) j = j - N_SRC;
      pcnt = pcnt + {4'd0, pend[k]};
      if (!found && pend[j]) begin
        found = 1'b1;
        sel   = ID_W'(j);
      end
    end
    multi    = (pcnt > 5'd1);
    load     = found && ((state == IDLE) || out_ready);
    load_hit = '0;
    if (load) load_hit[sel] = 1'b1;
    ovf_set  = set_req & pend & ~load_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt <= '0;
      s1     <= '0;
      s2     <= '0;
      arm1   <= 1'b0;
      armed  <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      s1     <= evt_in;
      s2     <= s1;
      arm1   <= 1'b1;
      armed  <= arm1;
    end
  end

  // A repeat edge on a still-pending source is dropped and keeps the first timestamp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      ovf  <= '0;
      for (int i = 0; i < N_SRC; i++) ts_reg[i] <= '0;
    end else begin
      pend <= (pend & ~load_hit) | set_req;
      ovf  <= (clr_ovf ? '0 : ovf) | ovf_set;
      for (int i = 0; i < N_SRC; i++) begin
        if (set_req[i] && !ovf_set[i]) ts_reg[i] <= ts_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_id    <= '0;
      out_ts    <= '0;
      out_multi <= 1'b0;
      ptr       <= '0;
    end else begin
      if (load) begin
        state     <= PRESENT;
        out_id    <= sel;
        out_ts    <= ts_reg[sel];
        out_multi <= multi;
        ptr       <= (sel == ID_W'(N_SRC - 1)) ? '0 : sel + ID_W'(1);
      end else if ((state == PRESENT) && out_ready) begin
        state <= IDLE;
      end
    end
  end

`ifdef EVT_MERGE_DROP_CNT_EN
  logic [4:0]  ovf_num;
  logic [16:0] drop_sum;

  always_comb begin
    ovf_num = '0;
    for (int i = 0; i < N_SRC; i++) ovf_num = ovf_num + {4'd0, ovf_set[i]};
    drop_sum = {1'b0, drop_cnt} + {12'd0, ovf_num};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt <= '0;
    else      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_evt_merge_arbiter.sv
// Directed bench for evt_merge_arbiter (N_SRC=4, TS_W=4, POL=4'b0010); expected drop_cnt follows EVT_MERGE_DROP_CNT_EN.
module tb_evt_merge_arbiter;

  logic        clk, rst;
  logic [3:0]  evt_in, evt_mask;
  logic        out_valid, out_ready, out_multi, clr_ovf;
  logic [1:0]  out_id;
  logic [3:0]  out_ts, ovf;
  logic [15:0] drop_cnt;
  logic [3:0]  tb_ts;
  int          tests, failed;

  evt_merge_arbiter #(.N_SRC(4), .TS_W(4), .POL(4'b0010)) dut (
    .clk(clk), .rst(rst), .evt_in(evt_in), .evt_mask(evt_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_ts(out_ts), .out_multi(out_multi), .ovf(ovf),
    .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the free-running timestamp: cleared by reset, +1 per clock.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_ts <= 4'd0;
    else      tb_ts <= tb_ts + 4'd1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] evt, input logic [3:0] mask, input logic ready);
    evt_in    = evt;
    evt_mask  = mask;
    out_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  v, v2, exp_ts;
    logic [15:0] exp_drop;
    logic [1:0]  rr_ids [5];
    tests = 0;
    failed = 0;
    rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`ifdef EVT_MERGE_DROP_CNT_EN
    exp_drop = 16'd1;
`else
    exp_drop = 16'd0;
`endif

    rst = 1'b0;
    clr_ovf = 1'b0;
    applyStimulus(4'b0010, 4'hF, 1'b1);
    step(3);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_id", out_id, 0);
    checkOutput("rst_ts", out_ts, 0);
    checkOutput("rst_multi", out_multi, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    rst = 1'b1;
    step(4);

    // Simultaneous merge: src0 rises, src1 falls in the same cycle.
    v = tb_ts;
    applyStimulus(4'b0001, 4'hF, 1'b1);
    exp_ts = v + 4'd1;
    step(3);
    checkOutput("merge_valid0", out_valid, 1);
    checkOutput("merge_id0", out_id, 0);
    checkOutput("merge_ts0", out_ts, exp_ts);
    checkOutput("merge_multi0", out_multi, 1);
    step(1);
    checkOutput("merge_valid1", out_valid, 1);
    checkOutput("merge_id1", out_id, 1);
    checkOutput("merge_ts1", out_ts, exp_ts);
    checkOutput("merge_multi1", out_multi, 0);
    step(1);
    checkOutput("merge_idle", out_valid, 0);
    applyStimulus(4'b0010, 4'hF, 1'b1);
    step(3);

    // Single-edge latency: pend two clocks after sampling, out_valid one later, one beat.
    v = tb_ts;
    applyStimulus(4'b0011, 4'hF, 1'b1);
    exp_ts = v + 4'd1;
    step(1);
    checkOutput("lat_valid_k", out_valid, 0);
    step(1);
    checkOutput("lat_valid_k1", out_valid, 0);
    step(1);
    checkOutput("lat_valid", out_valid, 1);
    checkOutput("lat_id", out_id, 0);
    checkOutput("lat_ts", out_ts, exp_ts);
    checkOutput("lat_multi", out_multi, 0);
    step(1);
    checkOutput("lat_one_beat", out_valid, 0);
    applyStimulus(4'b0010, 4'hF, 1'b1);
    step(3);

    // Backpressure: src0 held, src2 edges twice while pending -> one drop.
    v = tb_ts;
    applyStimulus(4'b0011, 4'hF, 1'b0);
    exp_ts = v + 4'd1;
    step(3);
    checkOutput("bp_valid", out_valid, 1);
    v2 = tb_ts;
    applyStimulus(4'b0110, 4'hF, 1'b0);
    step(2);
    applyStimulus(4'b0010, 4'hF, 1'b0);
    step(2);
    applyStimulus(4'b0110, 4'hF, 1'b0);
    step(2);
    checkOutput("ovf_set", ovf, 4'b0100);
    checkOutput("bp_hold_valid", out_valid, 1);
    checkOutput("bp_hold_id", out_id, 0);
    checkOutput("bp_hold_ts", out_ts, exp_ts);
    checkOutput("ovf_drop_cnt", drop_cnt, exp_drop);
    applyStimulus(4'b0010, 4'hF, 1'b1);
    step(1);
    checkOutput("ovf_beat_valid", out_valid, 1);
    checkOutput("ovf_beat_id", out_id, 2);
    checkOutput("ovf_beat_ts", out_ts, v2 + 4'd1);
    checkOutput("ovf_beat_multi", out_multi, 0);
    step(1);
    checkOutput("ovf_single_beat", out_valid, 0);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    checkOutput("ovf_clear", ovf, 0);
    checkOutput("drop_kept", drop_cnt, exp_drop);

    // A src3 beat moves the round-robin pointer back to 0.
    applyStimulus(4'b1010, 4'hF, 1'b1);
    step(3);
    checkOutput("src3_id", out_id, 3);
    applyStimulus(4'b0010, 4'hF, 1'b1);
    step(3);

    // Round-robin: every source re-edges every 2 cycles.
    v = tb_ts;
    applyStimulus(4'b1101, 4'hF, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (i >= 2) begin
        checkOutput("rr_valid", out_valid, 1);
        checkOutput("rr_id", out_id, rr_ids[i-2]);
      end
      if (i == 2) checkOutput("rr_first_multi", out_multi, 1);
      evt_in = ~evt_in;
    end
    applyStimulus(4'b0010, 4'hF, 1'b1);
    for (int i = 0; i < 20 && out_valid; i++) step(1);
    checkOutput("rr_drain", out_valid, 0);

    // Reset mid-transfer, with src0 held high across release.
    applyStimulus(4'b1010, 4'hF, 1'b0);
    step(3);
    checkOutput("mid_valid", out_valid, 1);
    checkOutput("mid_id", out_id, 3);
    rst = 1'b0;
    evt_in = 4'b0011;
    #1;
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_id", out_id, 0);
    checkOutput("mid_rst_ts", out_ts, 0);
    checkOutput("mid_rst_ovf", ovf, 0);
    checkOutput("mid_rst_drop", drop_cnt, 0);
    step(2);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      checkOutput("release_no_evt", out_valid, 0);
    end

    // Masked source edges are ignored.
    applyStimulus(4'b0111, 4'b1011, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      checkOutput("mask_no_beat", out_valid, 0);
    end
    applyStimulus(4'b0011, 4'hF, 1'b1);
    step(1);
    applyStimulus(4'b0010, 4'hF, 1'b1);
    step(1);
    checkOutput("mask_still_idle", out_valid, 0);

    // Timestamp wrap: src0 captured at 15, src1 at 0.
    for (int i = 0; i < 20 && tb_ts != 4'd14; i++) step(1);
    applyStimulus(4'b0011, 4'hF, 1'b1);
    step(1);
    applyStimulus(4'b0001, 4'hF, 1'b1);
    step(2);
    checkOutput("wrap_valid0", out_valid, 1);
    checkOutput("wrap_id0", out_id, 0);
    checkOutput("wrap_ts15", out_ts, 4'd15);
    step(1);
    checkOutput("wrap_valid1", out_valid, 1);
    checkOutput("wrap_id1", out_id, 1);
    checkOutput("wrap_ts0", out_ts, 4'd0);
    step(1);
    checkOutput("wrap_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
